// File: rtl/icache_refill_responder_pkg.sv
// Shared constants and types for the I-cache refill responder.
// Holds the core address and data widths, the refill block geometry and the refill FSM state type.
// Ports: none (package).
package icache_refill_responder_pkg;

   localparam int pc_size                = 32;
   localparam int data_size              = 32;
   localparam int icache_blocksize       = 512;
   localparam int icache_words_per_block = icache_blocksize / data_size;

   typedef enum logic [1:0] {
      RF_IDLE,
      RF_WAIT,
      RF_BURST
   } refill_state;

endpackage

// File: rtl/icache_refill_responder_imem_word_array.sv
// Purpose: instruction backing store with one synchronous write port and one combinational read port.
// Latency: a write lands on the clock edge; the read is combinational.
// Backpressure: none. A read and a write to the same word in one cycle return the old data.
// Ports: clk; we/waddr/wdata = preload write; raddr/rdata = beat read.
module imem_word_array
   import icache_refill_responder_pkg::*;
#(
   parameter int WORD_BITS = data_size,
   parameter int MEM_WORDS = 4096
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] waddr,
   input  logic [WORD_BITS-1:0]         wdata,
   input  logic [$clog2(MEM_WORDS)-1:0] raddr,
   output logic [WORD_BITS-1:0]         rdata
);

   logic [WORD_BITS-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/icache_refill_responder.sv
// Purpose: I-cache refill responder. Returns a 64-byte block as 16 beats, critical word first, wrapping in the block.
// Latency: the first beat is valid in the cycle after edge LATENCY, counting the accept edge as edge 0. Later beats follow with no bubble.
// Backpressure: rsp_ready low holds every rsp_* output and the beat counter. One request at a time; req_valid is ignored while busy.
// Ports: clk, rst (sync, active-high); req_* = refill request; rsp_* = beat stream; prog_* = preload write port.
module icache_refill_responder
   import icache_refill_responder_pkg::*;
#(
   parameter int BLOCK_BITS = icache_blocksize,
   parameter int WORD_BITS  = data_size,
   parameter int MEM_WORDS  = 4096,
   parameter int LATENCY    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [pc_size-1:0]           req_addr,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WORD_BITS-1:0]         rsp_data,
   output logic [3:0]                   rsp_word_idx,
   output logic                         rsp_last,
   input  logic                         prog_we,
   input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
   input  logic [WORD_BITS-1:0]         prog_data
);

   localparam int         AW        = $clog2(MEM_WORDS);
   localparam int         WPB       = BLOCK_BITS / WORD_BITS;
   localparam logic [3:0] LAST_BEAT = 4'(WPB - 1);
   localparam int         BASE_BITS = pc_size - 6;

   refill_state          state;
   logic [BASE_BITS-1:0] block_base;
   logic [3:0]           start_idx;
   logic [3:0]           beat_cnt;
   logic [15:0]          lat_cnt;

   logic [3:0]           load_beat;
   logic [3:0]           load_idx;
   logic [pc_size-3:0]   word_addr;
   logic [AW-1:0]        mem_raddr;
   logic [WORD_BITS-1:0] mem_rdata;
   logic                 accept;
   logic                 load_first;
   logic                 load_next;
   logic                 burst_done;
   logic                 unused_bits;

   assign accept = req_valid && req_ready;

   // In RF_BURST, rsp_valid low means beat 0 has not been loaded yet.
   // Entering the burst state this way makes every LATENCY value use the
   // same path: the WAIT state fills the cycles before it.
   assign load_first = (state == RF_BURST) && !rsp_valid;
   assign load_next  = (state == RF_BURST) && rsp_valid && rsp_ready && (beat_cnt != LAST_BEAT);
   assign burst_done = (state == RF_BURST) && rsp_valid && rsp_ready && (beat_cnt == LAST_BEAT);

   assign load_beat = rsp_valid ? beat_cnt + 4'd1 : 4'd0;
   assign load_idx  = start_idx + load_beat;

   // Truncating to the store depth is what makes out-of-range blocks alias.
   assign word_addr = {block_base, load_idx};
   assign mem_raddr = word_addr[AW-1:0];

   assign unused_bits = ^{req_addr[1:0], word_addr};

   imem_word_array #(
      .WORD_BITS (WORD_BITS),
      .MEM_WORDS (MEM_WORDS)
   ) u_mem (
      .clk   (clk),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RF_IDLE;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_last     <= 1'b0;
         rsp_data     <= '0;
         rsp_word_idx <= '0;
         block_base   <= '0;
         start_idx    <= '0;
         beat_cnt     <= '0;
         lat_cnt      <= '0;
      end else begin
         case (state)
            RF_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  block_base <= req_addr[pc_size-1:6];
                  start_idx  <= req_addr[5:2];
                  beat_cnt   <= '0;
                  req_ready  <= 1'b0;
                  if (LATENCY > 1) begin
                     state   <= RF_WAIT;
                     lat_cnt <= 16'(LATENCY > 1 ? LATENCY - 2 : 0);
                  end else begin
                     state <= RF_BURST;
                  end
               end
            end
            RF_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= RF_BURST;
               end else begin
                  lat_cnt <= lat_cnt - 16'd1;
               end
            end
            RF_BURST: begin
               if (load_first || load_next) begin
                  rsp_valid    <= 1'b1;
                  rsp_data     <= mem_rdata;
                  rsp_word_idx <= load_idx;
                  rsp_last     <= (load_beat == LAST_BEAT);
                  beat_cnt     <= load_beat;
               end else if (burst_done) begin
                  state     <= RF_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state <= RF_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: a scoreboard of expected beats is filled when a request is driven.
// Each scenario task pops the scoreboard and compares it with the beats the DUT hands over.
// Ports: none (top-level bench).
module tb_icache_refill_responder;

   localparam int MW = 4096;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_word_idx;
   logic        rsp_last;
   logic        prog_we;
   logic [11:0] prog_addr;
   logic [31:0] prog_data;

   beat_t       exp_q[$];
   beat_t       obs_q[$];
   logic [31:0] model_mem [MW];

   int n_checks = 0;
   int n_fail   = 0;
   int lat, span, serr, brdy;

   always #5 clk = ~clk;

   icache_refill_responder #(
      .BLOCK_BITS (512),
      .WORD_BITS  (32),
      .MEM_WORDS  (MW),
      .LATENCY    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_word_idx (rsp_word_idx),
      .rsp_last     (rsp_last),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      model_mem[a] = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Issues one request, pushes its 16 expected beats, and records the beats the DUT delivers.
   // mode 0: rsp_ready held high. mode 1: 3-cycle stall on beat 5, then random ready.
   // Returns once all beats are handed over (last acceptance at the next edge) or abort_after beats are in.
   task automatic run_burst(input logic [31:0] addr, input int mode, input int abort_after,
                            input bit busy, input logic [31:0] busy_addr,
                            input bit coll, input logic [3:0] coll_after_idx, input logic [11:0] coll_word,
                            output int lat_o, output int span_o, output int stall_err, output int busy_rdy);
      int    k;
      int    acc;
      int    stall_n;
      bit    prev_stalled;
      beat_t cur;
      beat_t prev;
      logic [25:0] base;
      logic [3:0]  st;
      lat_o = -1; span_o = 0; stall_err = 0; busy_rdy = 0;
      acc = 0; stall_n = 0; prev_stalled = 1'b0; prev = '0;
      obs_q.delete();
      k = 0;
      while (req_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      base = addr[31:6];
      st   = addr[5:2];
      for (int n = 0; n < 16; n++) begin
         logic [3:0]  ix;
         logic [29:0] wa;
         ix = st + 4'(n);
         wa = {base, ix};
         exp_q.push_back(beat_t'{ix, model_mem[wa[11:0]], (n == 15)});
      end
      req_valid = 1'b1;
      req_addr  = addr;
      rsp_ready = 1'b1;
      k = 0;
      while (acc < 16 && k < 400) begin
         @(negedge clk);
         k++;
         prog_we = 1'b0;
         if (busy) begin
            req_valid = 1'b1;
            req_addr  = busy_addr;
            if (req_ready === 1'b1) busy_rdy++;
         end else begin
            req_valid = 1'b0;
         end
         cur = beat_t'{rsp_word_idx, rsp_data, rsp_last};
         if (rsp_valid === 1'b1) begin
            if (lat_o < 0) lat_o = k - 1;
            if (prev_stalled && cur !== prev) stall_err++;
            if (mode == 1 && acc == 5 && stall_n < 3) begin
               rsp_ready = 1'b0;
               stall_n++;
            end else if (mode == 1 && acc > 5) begin
               rsp_ready = 1'($urandom_range(0, 1));
            end else begin
               rsp_ready = 1'b1;
            end
            if (rsp_ready) begin
               obs_q.push_back(cur);
               acc++;
               if (coll && cur.idx == coll_after_idx) begin
                  prog_we   = 1'b1;
                  prog_addr = coll_word;
                  prog_data = 32'hDEAD_BEEF;
                  model_mem[coll_word] = 32'hDEAD_BEEF;
               end
            end
            prev_stalled = !rsp_ready;
            prev = cur;
         end else begin
            rsp_ready = 1'b1;
            prev_stalled = 1'b0;
         end
         if (abort_after > 0 && acc == abort_after) break;
      end
      span_o = k - lat_o;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_last !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_last: got %b want 0", rsp_last); end
      n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      n_checks++; if (rsp_word_idx !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_idx: got %h want 0", rsp_word_idx); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 128; k++) preload(12'(k), 32'h1000_0000 + k);
      run_burst(32'h0000_0040, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
      n_checks++; if (span != 16) begin n_fail++; $display("FAIL basic_span: got %0d want 16", span); end
      n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL basic_count: got %0d want 16", obs_q.size()); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
      n_checks++; if (obs_q.size() > 15 && obs_q[15].data !== 32'h1000_001F) begin n_fail++; $display("FAIL basic_last_data: got %h want 1000001f", obs_q[15].data); end
   endtask

   task automatic test_critical_word();
      run_burst(32'h0000_0074, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL cwf_count: got %0d want 16", obs_q.size()); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL cwf_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
      if (obs_q.size() == 16) begin
         n_checks++; if (obs_q[0].idx !== 4'd13 || obs_q[0].data !== 32'h1000_001D) begin n_fail++; $display("FAIL cwf_first: got idx %0d data %h want idx 13 data 1000001d", obs_q[0].idx, obs_q[0].data); end
         n_checks++; if (obs_q[15].data !== 32'h1000_001C) begin n_fail++; $display("FAIL cwf_last: got %h want 1000001c", obs_q[15].data); end
      end
   endtask

   task automatic test_backpressure();
      run_burst(32'h0000_0088, 1, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (serr != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", serr); end
      n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", obs_q.size()); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL bp_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
   endtask

   task automatic test_busy_request();
      run_burst(32'h0000_00C0, 0, 0, 1'b1, 32'h0000_0100, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (brdy != 0) begin n_fail++; $display("FAIL busy_ready: got %0d cycles with ready high want 0", brdy); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL busy_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_after_last: got %b want 1", req_ready); end
      // The pending request is still asserted, so it is accepted on the next edge.
      run_burst(32'h0000_0100, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL busy_second_latency: got %0d want 2", lat); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL busy2_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
   endtask

   task automatic test_reset_mid_burst();
      run_burst(32'h0000_0148, 0, 7, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_beat%0d: got idx %h data %h want idx %h data %h", i, o.idx, o.data, e.idx, e.data); end
      end
      exp_q.delete();
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rsp_valid); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_residual: got %b want 0", rsp_valid); end
      run_burst(32'h0000_0148, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      n_checks++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL rstmid_new_count: got %0d want 16", obs_q.size()); end
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_new_beat%0d: got idx %h data %h last %b want idx %h data %h last %b", i, o.idx, o.data, o.last, e.idx, e.data, e.last); end
      end
   endtask

   task automatic test_alias();
      run_burst(32'h0000_4000, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL alias_beat%0d: got idx %h data %h want idx %h data %h", i, o.idx, o.data, e.idx, e.data); end
      end
      n_checks++; if (obs_q.size() > 0 && obs_q[0].data !== 32'h1000_0000) begin n_fail++; $display("FAIL alias_word0: got %h want 10000000", obs_q[0].data); end
   endtask

   task automatic test_collision();
      for (int k = 0; k < 16; k++) preload(12'h400 + 12'(k), 32'h2000_0400 + k);
      run_burst(32'h0000_1000, 0, 0, 1'b0, '0, 1'b1, 4'd0, 12'h401, lat, span, serr, brdy);
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL coll_beat%0d: got idx %h data %h want idx %h data %h", i, o.idx, o.data, e.idx, e.data); end
      end
      n_checks++; if (obs_q.size() > 1 && obs_q[1].data !== 32'h2000_0401) begin n_fail++; $display("FAIL coll_old_data: got %h want 20000401", obs_q[1].data); end
      run_burst(32'h0000_1000, 0, 0, 1'b0, '0, 1'b0, '0, '0, lat, span, serr, brdy);
      for (int i = 0; i < 16; i++) begin
         beat_t e, o;
         e = exp_q.pop_front();
         o = '0; if (i < obs_q.size()) o = obs_q[i];
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL coll2_beat%0d: got idx %h data %h want idx %h data %h", i, o.idx, o.data, e.idx, e.data); end
      end
      n_checks++; if (obs_q.size() > 1 && obs_q[1].data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL coll_new_data: got %h want deadbeef", obs_q[1].data); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_critical_word();
      test_backpressure();
      test_busy_request();
      test_reset_mid_burst();
      test_alias();
      test_collision();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for the I-cache refill interface. It accepts one block-refill request at a time and returns the addressed 64-byte block as 16 sequential 32-bit beats, critical word first, wrapping within the block. It sits between the I-cache miss handler and the instruction backing store. It also provides a preload port so the bench and boot loader can fill the store.

## Interface
- `BLOCK_BITS`, default `icache_blocksize` (512): refill block size in bits.
- `WORD_BITS`, default `data_size` (32): beat width.
- `MEM_WORDS`, default 4096: backing-store depth in words. Must be a power of two.
- `LATENCY`, default 2: cycles from request acceptance to the first beat. Must be ≥1.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `req_valid`  in  1  refill request.
- `req_ready`  out  1  responder idle and able to accept a request.
- `req_addr`  in  `pc_size`  byte address of the missing word.
- `rsp_valid`  out  1  beat valid.
- `rsp_ready`  in  1  cache accepts the beat.
- `rsp_data`  out  `WORD_BITS`  beat data.
- `rsp_word_idx`  out  4  word offset of the beat within the block.
- `rsp_last`  out  1  final (16th) beat of the burst.
- `prog_we`  in  1  preload write strobe.
- `prog_addr`  in  `log2(MEM_WORDS)`  preload word address.
- `prog_data`  in  `WORD_BITS`  preload data.

## Operation
- The FSM has three states: `RF_IDLE`, `RF_WAIT`, `RF_BURST`.
- `req_ready` equals 1 only in `RF_IDLE`.
- A request is accepted on the edge where `req_valid && req_ready`. On acceptance, the responder latches:
  - block base = `req_addr[pc_size-1:6]`;
  - start index = `req_addr[5:2]`;
  - beat counter = 0.
- `req_addr[1:0]` is ignored.
- Transitions:
  - `RF_IDLE` → `RF_WAIT` if `LATENCY > 1`, otherwise directly → `RF_BURST`.
  - `RF_WAIT` counts down `LATENCY-1` cycles, then → `RF_BURST`.
  - `RF_BURST` → `RF_IDLE` on the edge where the last beat is accepted.
- Beat n has `rsp_word_idx = (start + n) mod 16`. For example, start 13 gives the order 13, 14, 15, 0, 1, …, 12.
- Store word address for a beat = `{block_base, rsp_word_idx}` mod `MEM_WORDS`. Addresses beyond the store alias; they do not fault.
- `rsp_data` and `rsp_word_idx` are registered. They hold stable while `rsp_valid && !rsp_ready`.
- The next beat is presented on the cycle after acceptance. There is no bubble while `rsp_ready` stays high.
- `rsp_last` is high only when the beat counter equals 15.
- Preload writes are accepted in every state.
- A write that coincides with a beat load of the same word is read-before-write: the beat carries the old data.
- `req_valid` outside `RF_IDLE` is ignored. No request is queued.

## Timing
- Reset values: `req_ready` = 0 during the reset cycle and 1 on the first cycle after it; `rsp_valid`, `rsp_last` = 0; `rsp_data`, `rsp_word_idx` = 0; state = `RF_IDLE`.
- Reset asserted mid-burst aborts immediately. The next cycle has `rsp_valid` = 0 and state `RF_IDLE`, and no residual beats appear.
- If the request is accepted at edge 0, the first beat has `rsp_valid` = 1 in the cycle after edge `LATENCY`.
- With `rsp_ready` held high, the burst occupies 16 consecutive cycles.
- After the `rsp_last` beat is accepted, `req_ready` returns high in the next cycle. Minimum request-to-request spacing is `LATENCY + 17` cycles.
- Backpressure: `rsp_ready` low stalls the counter and holds all `rsp_*` outputs. It never drops or duplicates a beat.

## Structure
- Add to the shared constants package:
  - typedef enum `refill_state` {`RF_IDLE`, `RF_WAIT`, `RF_BURST`};
  - define `icache_words_per_block` = `icache_blocksize`/`data_size` (16).
- Sub-module `imem_word_array` holds the store:
  - one synchronous write port (preload);
  - one combinational read port, sampled into `rsp_data`.
- The FSM, latency counter, beat counter and output registers live in the top module.

## Test plan
- Basic: preload word k with value 0x1000_0000+k, then request `req_addr` 0x0000_0040 with `LATENCY` 2 and `rsp_ready`=1. Required: first beat two cycles after acceptance, 16 beats with idx 0..15 and data 0x1000_0010..0x1000_001F, `rsp_last` on beat 16 only.
- Critical word first: request 0x0000_0074. Required: idx order 13, 14, 15, 0..12; first data 0x1000_001D, last data 0x1000_001C.
- Backpressure: hold `rsp_ready` low for 3 cycles on beat 5, then toggle it 1/0 randomly. Required: `rsp_data` and idx stable while stalled, exactly 16 accepted beats, no duplicates.
- Busy request: assert `req_valid` with a different address during `RF_BURST`. Required: `req_ready`=0 and the burst is unaffected. The request is accepted in the cycle after the last beat's acceptance.
- Reset mid-burst: assert `rst` after beat 7. Required: `rsp_valid`=0 on the next cycle and `req_ready`=1 one cycle after `rst` deasserts. A new request then returns a full, correct block.
- Aliasing and preload collision (`MEM_WORDS`=4096): request 0x0000_4000 and check it returns words 0..15. In a separate run, write word 0x401 on the cycle beat idx 1 of a request to 0x0000_1000 loads. Required: that beat returns the old value.
